// File: rtl/limber_gnrl_pipe.sv
// Elastic register pipeline with valid/ready handshakes on both ends. Bubbles collapse forward.
// Optional synchronous flush port is compiled in when LIMBER_GNRL_PIPE_FLUSH_EN is defined.
module limber_gnrl_pipe #(
    parameter int DW     = 8,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef LIMBER_GNRL_PIPE_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        i_vld,
    output logic                        i_rdy,
    input  logic [DW-1:0]               i_dat,
    output logic                        o_vld,
    input  logic                        o_rdy,
    output logic [DW-1:0]               o_dat,
    output logic [$clog2(STAGES+1)-1:0] o_cnt
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] vld_r;
    logic [DW-1:0]     dat_r [STAGES];
    logic [CW-1:0]     cnt_r;
    logic [STAGES-1:0] acc_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] leave_s;
    logic [STAGES-1:0] vld_nxt_s;
    logic              chain_s;
    logic              flush_s;
    logic              in_xfer_s;
    logic              out_xfer_s;

`ifdef LIMBER_GNRL_PIPE_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Accept chain: a slot can load when it is empty or everything downstream of it moves.
    always_comb begin
        acc_s   = '0;
        chain_s = o_rdy;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc_s[k] = ~vld_r[k] | chain_s;
            chain_s  = acc_s[k];
        end
    end

    assign i_rdy = acc_s[0] & ~flush_s;

    // Per-slot load/leave decisions and next valid vector.
    always_comb begin
        load_s     = '0;
        leave_s    = '0;
        vld_nxt_s  = '0;
        in_xfer_s  = i_vld & i_rdy;
        out_xfer_s = vld_r[STAGES-1] & o_rdy;
        load_s[0]  = in_xfer_s;
        for (int k = 1; k < STAGES; k++) begin
            load_s[k] = vld_r[k-1] & acc_s[k] & ~flush_s;
        end
        for (int k = 0; k < STAGES - 1; k++) begin
            leave_s[k] = load_s[k+1];
        end
        leave_s[STAGES-1] = out_xfer_s;
        for (int k = 0; k < STAGES; k++) begin
            if (flush_s) begin
                vld_nxt_s[k] = 1'b0;
            end else begin
                vld_nxt_s[k] = load_s[k] | (vld_r[k] & ~leave_s[k]);
            end
        end
    end

    // Slot state, data and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= '0;
            cnt_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_r[k] <= '0;
            end
        end else begin
            vld_r <= vld_nxt_s;
            if (flush_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(in_xfer_s) - CW'(out_xfer_s);
            end
            if (load_s[0]) begin
                dat_r[0] <= i_dat;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load_s[k]) begin
                    dat_r[k] <= dat_r[k-1];
                end
            end
        end
    end

    assign o_vld = vld_r[STAGES-1];
    assign o_dat = dat_r[STAGES-1];
    assign o_cnt = cnt_r;

endmodule

// File: tb/tb_limber_gnrl_pipe.sv
// Directed bench for limber_gnrl_pipe (DW=8, STAGES=3): vector table plus reset/stream/flush sequences.
module tb_limber_gnrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_vld;
    logic       i_rdy;
    logic [7:0] i_dat;
    logic       o_vld;
    logic       o_rdy;
    logic [7:0] o_dat;
    logic [1:0] o_cnt;
`ifdef LIMBER_GNRL_PIPE_FLUSH_EN
    logic       flush;
`endif

    int n_cmp = 0;
    int n_err = 0;

    limber_gnrl_pipe #(.DW(8), .STAGES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef LIMBER_GNRL_PIPE_FLUSH_EN
        .flush (flush),
`endif
        .i_vld (i_vld),
        .i_rdy (i_rdy),
        .i_dat (i_dat),
        .o_vld (o_vld),
        .o_rdy (o_rdy),
        .o_dat (o_dat),
        .o_cnt (o_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       ordy;
        logic       irdy;
        logic       ovld;
        logic [7:0] odat;
        logic       chk_dat;
        logic [1:0] cnt;
    } vec_t;

    vec_t tv [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inputs before edge: vld dat ordy | expected: irdy (pre-edge) ovld odat chk_dat cnt (post-edge)
        tv[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1};
        tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1};
        tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 2'd1};
        tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
        tv[4]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1};
        tv[5]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2};
        tv[6]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 2'd3};
        tv[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'd3};
        tv[8]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 2'd3};
        tv[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 2'd3};
        tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 2'd2};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 2'd1};
        tv[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
        tv[13] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1};
        tv[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1};
        tv[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd1};
        tv[16] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd2};
        tv[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd2};
        tv[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd2};
        tv[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1};
        tv[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};

        // Reset for two edges while upstream offers a payload.
        rst_n = 1'b0;
        i_vld = 1'b1;
        i_dat = 8'hAA;
        o_rdy = 1'b1;
`ifdef LIMBER_GNRL_PIPE_FLUSH_EN
        flush = 1'b0;
`endif
        step();
        step();
        rst_n = 1'b1;
        i_vld = 1'b0;
        #1;
        check("reset_o_vld", 32'(o_vld), 32'd0);
        check("reset_o_dat", 32'(o_dat), 32'h00);
        check("reset_o_cnt", 32'(o_cnt), 32'd0);
        check("reset_i_rdy", 32'(i_rdy), 32'd1);

        // Table: latency, backpressure, full-and-drain, bubble collapse.
        for (int i = 0; i < 21; i++) begin
            i_vld = tv[i].vld;
            i_dat = tv[i].dat;
            o_rdy = tv[i].ordy;
            #1;
            check($sformatf("v%0d_i_rdy", i), 32'(i_rdy), 32'(tv[i].irdy));
            step();
            check($sformatf("v%0d_o_vld", i), 32'(o_vld), 32'(tv[i].ovld));
            check($sformatf("v%0d_o_cnt", i), 32'(o_cnt), 32'(tv[i].cnt));
            if (tv[i].chk_dat) begin
                check($sformatf("v%0d_o_dat", i), 32'(o_dat), 32'(tv[i].odat));
            end
        end

        // Steady-state streaming: one transfer per cycle, in order.
        o_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_vld = (c < 8) ? 1'b1 : 1'b0;
            i_dat = 8'(8'hC0 + c);
            step();
            if (c >= 2 && c < 10) begin
                check($sformatf("stream%0d_o_vld", c), 32'(o_vld), 32'd1);
                check($sformatf("stream%0d_o_dat", c), 32'(o_dat), 32'(8'hC0 + c - 2));
            end else if (c >= 10) begin
                check($sformatf("stream%0d_o_vld", c), 32'(o_vld), 32'd0);
            end
            if (c >= 2 && c < 8) begin
                check($sformatf("stream%0d_o_cnt", c), 32'(o_cnt), 32'd3);
            end
        end

        // Reset in the middle of operation discards held payloads.
        o_rdy = 1'b0;
        i_vld = 1'b1;
        i_dat = 8'h33;
        step();
        i_dat = 8'h34;
        step();
        check("midrst_pre_cnt", 32'(o_cnt), 32'd2);
        rst_n = 1'b0;
        i_dat = 8'h77;
        step();
        rst_n = 1'b1;
        i_vld = 1'b0;
        #1;
        check("midrst_o_vld", 32'(o_vld), 32'd0);
        check("midrst_o_dat", 32'(o_dat), 32'h00);
        check("midrst_o_cnt", 32'(o_cnt), 32'd0);
        check("midrst_i_rdy", 32'(i_rdy), 32'd1);
        o_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("midrst_idle%0d_o_vld", c), 32'(o_vld), 32'd0);
        end

`ifdef LIMBER_GNRL_PIPE_FLUSH_EN
        // Flush a full pipe while upstream offers a payload.
        o_rdy = 1'b0;
        i_vld = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_dat = 8'(8'hE0 + c);
            step();
        end
        check("flush_pre_cnt", 32'(o_cnt), 32'd3);
        flush = 1'b1;
        i_dat = 8'h99;
        #1;
        check("flush_i_rdy", 32'(i_rdy), 32'd0);
        step();
        flush = 1'b0;
        i_vld = 1'b0;
        #1;
        check("flush_o_vld", 32'(o_vld), 32'd0);
        check("flush_o_cnt", 32'(o_cnt), 32'd0);
        o_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("flush_idle%0d_o_vld", c), 32'(o_vld), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/limber_gnrl_pipe.md
LIMBER_GNRL_PIPE -- requirements
Module: limber_gnrl_pipe

Interface
- REQ-001 SHALL have parameter DW, default 8: payload width in bits (>=1).
- REQ-002 SHALL have parameter STAGES, default 2: number of register slots in the chain (>=1).
- REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
- REQ-005 SHALL have port i_vld, input, 1: upstream payload valid.
- REQ-006 SHALL have port i_rdy, output, 1: pipe can accept a payload this cycle.
- REQ-007 SHALL have port i_dat, input, DW: upstream payload.
- REQ-008 SHALL have port o_vld, output, 1: last slot holds a valid payload.
- REQ-009 SHALL have port o_rdy, input, 1: downstream accepts the payload.
- REQ-010 SHALL have port o_dat, output, DW: payload of the last slot.
- REQ-011 SHALL have port o_cnt, output, $clog2(STAGES+1): number of occupied slots.
- REQ-012 SHALL have port flush, input, 1, present only when LIMBER_GNRL_PIPE_FLUSH_EN is defined.

Function
- REQ-013 SHALL hold slots 0..STAGES-1; slot 0 is fed from i_dat and slot STAGES-1 drives o_vld/o_dat.
- REQ-014 SHALL transfer on the input side when i_vld & i_rdy, and on the output side when o_vld & o_rdy.
- REQ-015 SHALL, for each slot k, accept (load) in a cycle when it is empty or its content moves to slot k+1 (or out, for the last slot).
- REQ-016 SHALL advance slot k into slot k+1 when slot k is valid and slot k+1 accepts; bubbles therefore collapse.
- REQ-017 SHALL drive i_rdy = slot-0 accept condition; i_rdy may depend combinationally on o_rdy.
- REQ-018 SHALL make a payload accepted at edge N, on an empty pipe with o_rdy held high, appear on o_vld/o_dat after edge N+STAGES-1 (first visible STAGES cycles after the accept cycle).
- REQ-019 SHALL sustain one transfer per cycle at steady state when i_vld and o_rdy stay high.
- REQ-020 SHALL keep o_dat and o_vld stable while o_vld & ~o_rdy (no payload loss, duplication or reorder).
- REQ-021 SHALL accept a new payload into a full pipe in the same cycle that o_rdy drains the last slot.
- REQ-022 SHALL update o_cnt registered: o_cnt(next) = o_cnt + in_xfer - out_xfer, range 0..STAGES; simultaneous in/out transfer leaves o_cnt unchanged.
- REQ-023 SHALL leave slot data registers unchanged when not loading; the data value in an empty slot is don't-care except after reset.

Reset
- REQ-024 SHALL, on rising clk with rst_n=0, clear all slot valid bits, clear all slot data to 0 and set o_cnt to 0.
- REQ-025 SHALL therefore present o_vld=0, o_dat=0, o_cnt=0 and i_rdy=1 in the cycle after reset is sampled, discarding any in-flight payloads (reset mid-operation included).
- REQ-026 SHALL ignore i_vld while rst_n=0; no payload is captured in a reset cycle.

Configuration
- REQ-027 SHALL compile in the flush port and logic only when macro LIMBER_GNRL_PIPE_FLUSH_EN is defined.
- REQ-028 With LIMBER_GNRL_PIPE_FLUSH_EN, flush=1 at an edge SHALL clear all valid bits and o_cnt (data retained) and drop any simultaneous input; i_rdy SHALL be 0 while flush=1.
- REQ-029 Without LIMBER_GNRL_PIPE_FLUSH_EN, the flush port SHALL not exist and behaviour SHALL be as in REQ-013..REQ-023.

Verification (DW=8, STAGES=3)
- REQ-030 Reset: rst_n=0 for 2 cycles with i_vld=1, i_dat=8'hAA -> o_vld=0, o_dat=8'h00, o_cnt=0, i_rdy=1 afterwards.
- REQ-031 Latency: push 8'h11 at cycle 0 with o_rdy=1 -> o_vld=1, o_dat=8'h11 first seen at cycle 3, for exactly one cycle.
- REQ-032 Backpressure: o_rdy=0, push 8'h01..8'h04 -> 3 accepted, i_rdy=0 on the 4th, o_cnt=3; release o_rdy -> outputs 01,02,03 in order, then 04.
- REQ-033 Full-and-drain: full pipe, o_rdy=1, i_vld=1 with 8'h55 -> same-cycle accept, o_cnt stays 3.
- REQ-034 Bubble collapse: push 8'hA0, gap 2 cycles, push 8'hA1, with o_rdy=0 -> o_cnt=2, slots 2 and 1 occupied; o_rdy=1 -> A0 then A1 on consecutive cycles.
- REQ-035 Flush (macro defined): 3 payloads held, flush=1 for 1 cycle with i_vld=1 -> o_vld=0, o_cnt=0, no payload emitted.
